// File: rtl/datapath_pkg.sv
// Shared datapath definitions used by the scalar writeback arbiter.
//   WB_NREQ      : number of scalar writeback requesters
//   wb_req_t     : one buffered writeback result {rd, wdata}
//   wb_src_t     : requester index encoding (ALU, LD/ST, BR)
//   wb_next_idx  : modulo-n successor of an index
package datapath_pkg;

  localparam int WB_NREQ   = 3;
  localparam int WB_REG_W  = 5;
  localparam int WB_WORD_W = 32;

  typedef struct packed {
    logic [WB_REG_W-1:0]  rd;
    logic [WB_WORD_W-1:0] wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LDST = 2'd1,
    WB_BR   = 2'd2
  } wb_src_t;

  function automatic int wb_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
//   CLK, nRST   : clock, asynchronous active-low reset
//   req[N]      : request lines
//   en          : grant enable; no grant while low
//   grant[N]    : one-hot grant (combinational)
//   grant_idx   : binary index of the granted line
// The pointer moves to one past the winner only when a grant is issued.
import datapath_pkg::*;

module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_hit;

  // Search upward from r_ptr, wrapping; first requester found wins.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    w_hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_hit && en && req[j]) begin
        w_hit     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ptr <= '0;
    end else if (w_hit) begin
      r_ptr <= IDX_W'(wb_next_idx(int'(grant_idx), N));
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Scalar writeback arbiter: one-entry holding buffer per scalar unit,
// round-robin selection onto the single registered register-file write port.
//   CLK, nRST             : clock, asynchronous active-low reset
//   req_valid/rd/wdata    : per-requester result (packed, index 0 in LSBs)
//   req_ready             : buffer can accept this cycle
//   freeze                : suspends grants; buffers hold
//   out_wen/rd/wdata      : registered write port (x0 writes suppress wen)
//   out_done              : registered one-hot of the requester on the port
import datapath_pkg::*;

module wb_arbiter #(
  parameter int NREQ   = WB_NREQ,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*REG_W-1:0]  req_rd,
  input  logic [NREQ*WORD_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   freeze,
  output logic                   out_wen,
  output logic [REG_W-1:0]       out_rd,
  output logic [WORD_W-1:0]      out_wdata,
  output logic [NREQ-1:0]        out_done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   r_full;
  logic [REG_W-1:0]  r_rd [NREQ];
  logic [WORD_W-1:0] r_wd [NREQ];

  logic [NREQ-1:0]   w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic [NREQ-1:0]   w_accept;
  logic              w_en;

  assign w_en = ~freeze;

  rr_arbiter #(.N(NREQ)) u_rr (
    .CLK       (CLK),
    .nRST      (nRST),
    .req       (r_full),
    .en        (w_en),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // A buffer being drained this cycle may be refilled in the same cycle.
  assign req_ready = ~r_full | (w_grant & {NREQ{w_en}});
  assign w_accept  = req_valid & req_ready;

  // Stage p0: holding buffers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_full <= '0;
    end else begin
      r_full <= (r_full & ~w_grant) | w_accept;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept[i]) begin
        r_rd[i] <= req_rd[i*REG_W +: REG_W];
        r_wd[i] <= req_wdata[i*WORD_W +: WORD_W];
      end
    end
  end

  // Stage p1: registered write port; x0 still pulses done so the row retires
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_wen   <= 1'b0;
      out_rd    <= '0;
      out_wdata <= '0;
      out_done  <= '0;
    end else if (|w_grant) begin
      out_wen   <= |r_rd[w_gidx];
      out_rd    <= r_rd[w_gidx];
      out_wdata <= r_wd[w_gidx];
      out_done  <= w_grant;
    end else begin
      out_wen   <= 1'b0;
      out_done  <= '0;
    end
  end

endmodule
